// File: rtl/ps2.sv
// PS/2 keyboard receiver: synchronises PS2_CLK/PS2_DATA, assembles 11-bit frames
// and presents the last two valid scan-code bytes plus status LEDs.
module ps2 #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic        CLK,
    input  logic        reset,
    output logic [9:0]  LED,
    output logic [15:0] data_out,
    output logic        new_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   data_q, data_d;
    logic [9:0]    led_q, led_d;
    logic          new_code_q, new_code_d;
    logic          fall;
    logic          bit_val;

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign bit_val = data_sync_q[1];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            data_q      <= '0;
            led_q       <= '0;
            new_code_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
            led_q       <= led_d;
            new_code_q  <= new_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        led_d      = led_q;
        new_code_d = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                // The start bit is only accepted when it is 0, so CHECK need not re-test it.
                if (fall && !bit_val) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_d   = {bit_val, shift_q[9:1]};
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                // shift_q holds {stop, parity, data[7:0]}
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    data_d      = {data_q[7:0], shift_q[7:0]};
                    led_d[7:0]  = shift_q[7:0];
                    led_d[8]    = 1'b0;
                    led_d[9]    = (shift_q[7:0] == 8'hF0);
                    new_code_d  = 1'b1;
                end else begin
                    led_d[8] = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign LED      = led_q;
    assign data_out = data_q;
    assign new_code = new_code_q;

endmodule

// File: tb/tb_ps2.sv
// Directed bench for ps2: frames are bit-banged on the PS/2 lines and a
// scoreboard of expected {data_out, LED} is checked on every new_code strobe.
module tb_ps2;

    localparam int TMO = 100;

    logic        PS2_CLK;
    logic        PS2_DATA;
    logic        CLK;
    logic        reset;
    logic [9:0]  LED;
    logic [15:0] data_out;
    logic        new_code;

    ps2 #(.TIMEOUT_CYCLES(TMO)) dut (
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .CLK      (CLK),
        .reset    (reset),
        .LED      (LED),
        .data_out (data_out),
        .new_code (new_code)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int pulse_cnt  = 0;

    logic [25:0] exp_q[$];
    logic [15:0] exp_data = 16'h0000;
    logic [9:0]  exp_led  = 10'h000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive the first nbits of an LSB-first frame, one PS2_CLK period (100 ns) per bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = bits[i];
            #25 PS2_CLK = 1'b0;
            #50 PS2_CLK = 1'b1;
            #25;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par);
        logic valid;
        valid = ((^b) ^ par) == 1'b1;
        if (valid) begin
            exp_data     = {exp_data[7:0], b};
            exp_led[7:0] = b;
            exp_led[8]   = 1'b0;
            exp_led[9]   = (b == 8'hF0);
            exp_q.push_back({exp_data, exp_led});
        end else begin
            exp_led[8] = 1'b1;
        end
        send_bits({1'b1, par, b, 1'b0}, 11);
        #200;
        $display("frame byte=%h parity=%b valid=%b data_out=%h LED=%h pulses=%0d",
                 b, par, valid, data_out, LED, pulse_cnt);
        check("data_out", 32'(data_out), 32'(exp_data));
        check("LED", 32'(LED), 32'(exp_led));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: each strobe pops the expected output word and compares.
    always @(negedge CLK) begin
        if (reset && new_code) begin
            logic [25:0] e;
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'(new_code), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data_out", 32'(data_out), 32'(e[25:10]));
                check("sb_LED", 32'(LED), 32'(e[9:0]));
            end
        end
    end

    initial begin
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        reset    = 1'b0;
        #5;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_LED", 32'(LED), 32'h0);
        check("rst_new_code", 32'(new_code), 32'h0);
        reset = 1'b1;
        #500;
        $display("idle data_out=%h LED=%h pulses=%0d", data_out, LED, pulse_cnt);
        check("idle_data_out", 32'(data_out), 32'h0);
        check("idle_LED", 32'(LED), 32'h0);
        check("idle_pulses", 32'(pulse_cnt), 32'd0);

        send_frame(8'h75, 1'b0);
        check("pulses_after_1", 32'(pulse_cnt), 32'd1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h75, 1'b0);
        check("pulses_after_4", 32'(pulse_cnt), 32'd4);

        send_frame(8'h75, 1'b1);
        check("pulses_after_err", 32'(pulse_cnt), 32'd4);
        send_frame(8'h1C, 1'b0);
        check("pulses_after_recover", 32'(pulse_cnt), 32'd5);

        // Start bit plus four data bits, then silence well past the timeout.
        send_bits(11'b000_0000_1010, 5);
        #(TMO * 20 * 2);
        $display("timeout gap data_out=%h LED=%h pulses=%0d", data_out, LED, pulse_cnt);
        check("tmo_pulses", 32'(pulse_cnt), 32'd5);
        send_frame(8'h5A, 1'b1);
        check("pulses_final", 32'(pulse_cnt), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
